// File: rtl/bluetooth_at_pkg.sv
// Shared constants for the BLE UART AT command encoder: ASCII codes, command
// codes, FSM state encodings and the AT prefix ROM.
package bluetooth_at_pkg;

    // ASCII characters used by the AT command prefix and terminator
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_B    = 8'h42;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_L    = 8'h4C;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_T    = 8'h54;
    localparam logic [7:0] ASCII_U    = 8'h55;
    localparam logic [7:0] ASCII_X    = 8'h58;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // command_select codes
    localparam logic [1:0] CMD_INVALID = 2'd0;
    localparam logic [1:0] CMD_TX      = 2'd1;
    localparam logic [1:0] CMD_RX      = 2'd2;
    localparam logic [1:0] CMD_TX_HEX  = 2'd3;

    // FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PREFIX  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_TERM    = 2'd3;

    // "AT+BLEUARTTX=" is 13 bytes; the RX prefix drops the '=' (12 bytes)
    localparam int unsigned PREFIX_LEN   = 13;
    localparam int unsigned PREFIX_IDX_W = 4;

    // Prefix ROM: TX and RX share everything except index 10 and the '='
    function automatic logic [7:0] prefix_byte(input logic [PREFIX_IDX_W-1:0] idx,
                                               input logic is_rx);
        case (idx)
            4'd0:    prefix_byte = ASCII_A;
            4'd1:    prefix_byte = ASCII_T;
            4'd2:    prefix_byte = ASCII_PLUS;
            4'd3:    prefix_byte = ASCII_B;
            4'd4:    prefix_byte = ASCII_L;
            4'd5:    prefix_byte = ASCII_E;
            4'd6:    prefix_byte = ASCII_U;
            4'd7:    prefix_byte = ASCII_A;
            4'd8:    prefix_byte = ASCII_R;
            4'd9:    prefix_byte = ASCII_T;
            4'd10:   prefix_byte = is_rx ? ASCII_R : ASCII_T;
            4'd11:   prefix_byte = ASCII_X;
            4'd12:   prefix_byte = ASCII_EQ;
            default: prefix_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/nibble_to_ascii_hex.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
//   nibble  : value 0..15
//   ascii_c : '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
module nibble_to_ascii_hex
    import bluetooth_at_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii_c
);

    assign ascii_c = (nibble < 4'd10) ? (ASCII_ZERO + 8'(nibble))
                                      : (ASCII_A + 8'(nibble - 4'd10));

endmodule

// File: rtl/bluetooth_at_stream_encoder.sv
// Builds Adafruit BLE UART AT commands (TX raw, RX, TX hex) and streams them
// one ASCII byte per valid/ready handshake toward the UART transmitter.
//   clk, reset_n    : clock (rising edge), async active-low reset
//   start           : request, accepted only while busy=0
//   command_select  : 1=TX raw, 2=RX, 3=TX hex, 0=invalid
//   payload_data    : payload bytes, byte 0 in [7:0] and sent first
//   payload_len     : payload byte count for TX modes (1..MAX_BYTES)
//   out_byte/out_valid/out_ready : byte stream handshake
//   busy            : command in progress
//   done            : one-cycle pulse after the CR handshake
//   error           : one-cycle pulse after a rejected request
module bluetooth_at_stream_encoder
    import bluetooth_at_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 16,
    parameter int unsigned LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [1:0]             command_select,
    input  logic [8*MAX_BYTES-1:0] payload_data,
    input  logic [LEN_W-1:0]       payload_len,
    output logic [7:0]             out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    logic [1:0]              state_q, state_d;
    logic [PREFIX_IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [1:0]              cmd_q, cmd_d;
    logic [8*MAX_BYTES-1:0]  data_q, data_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [7:0]              out_byte_d;
    logic                    out_valid_d, busy_d, done_d, error_d;

    logic                    is_rx, is_hex, xfer, req_bad, pay_last, prefix_last;
    logic [LEN_W-1:0]        sel_cnt;
    logic                    sel_phase;
    int unsigned             sel_idx;
    logic [7:0]              sel_byte, hex_char, pay_char;

    assign is_rx  = (cmd_q == CMD_RX);
    assign is_hex = (cmd_q == CMD_TX_HEX);
    assign xfer   = out_valid & out_ready;

    // Request is rejected for an invalid code or an out-of-range TX length
    assign req_bad = (command_select == CMD_INVALID) ||
                     (((command_select == CMD_TX) || (command_select == CMD_TX_HEX)) &&
                      ((payload_len == '0) || (payload_len > LEN_W'(MAX_BYTES))));

    assign prefix_last = (idx_q == (is_rx ? PREFIX_IDX_W'(PREFIX_LEN - 2)
                                          : PREFIX_IDX_W'(PREFIX_LEN - 1)));
    assign pay_last    = (cnt_q == (len_q - LEN_W'(1))) && (!is_hex || phase_q);

    // Payload position to present after the current transfer
    always_comb begin
        sel_cnt   = cnt_q;
        sel_phase = 1'b0;
        if (state_q == ST_PREFIX) begin
            sel_cnt = '0;
        end else if (is_hex && !phase_q) begin
            sel_phase = 1'b1;
        end else begin
            sel_cnt = cnt_q + LEN_W'(1);
        end
    end

    // Clamp keeps the unused look-ahead past the last byte in range
    assign sel_idx  = (sel_cnt < LEN_W'(MAX_BYTES)) ? 32'(sel_cnt) : 32'd0;
    assign sel_byte = data_q[8*sel_idx +: 8];

    nibble_to_ascii_hex u_hex (
        .nibble  (sel_phase ? sel_byte[3:0] : sel_byte[7:4]),
        .ascii_c (hex_char)
    );

    assign pay_char = is_hex ? hex_char : sel_byte;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        len_d       = len_q;
        out_byte_d  = out_byte;
        out_valid_d = out_valid;
        busy_d      = busy;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cmd_d  = command_select;
                    data_d = payload_data;
                    len_d  = payload_len;
                    if (req_bad) begin
                        error_d = 1'b1;
                    end else begin
                        state_d     = ST_PREFIX;
                        idx_d       = '0;
                        cnt_d       = '0;
                        phase_d     = 1'b0;
                        out_byte_d  = prefix_byte('0, command_select == CMD_RX);
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
            end
            ST_PREFIX: begin
                if (xfer) begin
                    if (!prefix_last) begin
                        idx_d      = idx_q + PREFIX_IDX_W'(1);
                        out_byte_d = prefix_byte(idx_q + PREFIX_IDX_W'(1), is_rx);
                    end else if (is_rx) begin
                        state_d    = ST_TERM;
                        out_byte_d = ASCII_CR;
                    end else begin
                        state_d    = ST_PAYLOAD;
                        cnt_d      = sel_cnt;
                        phase_d    = sel_phase;
                        out_byte_d = pay_char;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (pay_last) begin
                        state_d    = ST_TERM;
                        out_byte_d = ASCII_CR;
                    end else begin
                        cnt_d      = sel_cnt;
                        phase_d    = sel_phase;
                        out_byte_d = pay_char;
                    end
                end
            end
            ST_TERM: begin
                if (xfer) begin
                    state_d     = ST_IDLE;
                    out_byte_d  = 8'h00;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            cmd_q     <= '0;
            data_q    <= '0;
            len_q     <= '0;
            out_byte  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            len_q     <= len_d;
            out_byte  <= out_byte_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_bluetooth_at_stream_encoder.sv
// Self-checking bench for bluetooth_at_stream_encoder: expected byte streams
// are built from the AT command text and payload, then compared per handshake.
module tb_bluetooth_at_stream_encoder;

    localparam int unsigned MAXB = 16;
    localparam int unsigned LW   = $clog2(MAXB + 1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        command_select = 2'd0;
    logic [8*MAXB-1:0] payload_data = '0;
    logic [LW-1:0]     payload_len = '0;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              error;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    bluetooth_at_stream_encoder #(.MAX_BYTES(MAXB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .command_select (command_select),
        .payload_data   (payload_data),
        .payload_len    (payload_len),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected stream from the command text: prefix, payload (raw or hex), CR
    function automatic void build_exp(input logic [1:0] cmd, input logic [8*MAXB-1:0] data,
                                      input int len);
        string pre;
        string hx;
        logic [7:0] b;
        hx = "0123456789ABCDEF";
        exp_q.delete();
        if (cmd == 2'd2) pre = "AT+BLEUARTRX";
        else             pre = "AT+BLEUARTTX=";
        for (int i = 0; i < pre.len(); i++) exp_q.push_back(pre[i]);
        if (cmd != 2'd2) begin
            for (int k = 0; k < len; k++) begin
                b = data[8*k +: 8];
                if (cmd == 2'd3) begin
                    exp_q.push_back(hx[b[7:4]]);
                    exp_q.push_back(hx[b[3:0]]);
                end else begin
                    exp_q.push_back(b);
                end
            end
        end
        exp_q.push_back(8'h0D);
    endfunction

    function automatic logic [8*MAXB-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Issue one accepted command and follow its byte stream to done
    task automatic run_cmd(input string tag, input logic [1:0] cmd, input logic [8*MAXB-1:0] data,
                           input int len, input bit stall);
        int got;
        int cyc;
        bit finished;
        bit stalled;
        logic [7:0] held;
        build_exp(cmd, data, len);
        check({tag, "_pre_busy"}, 32'(busy), 32'd0);
        check({tag, "_pre_done"}, 32'(done), 32'd0);
        command_select = cmd;
        payload_data   = data;
        payload_len    = LW'(len);
        start          = 1'b1;
        out_ready      = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        command_select = 2'($urandom());
        payload_data   = rand_data();
        payload_len    = LW'($urandom());
        check({tag, "_lat_byte"}, 32'(out_byte), 32'h41);
        check({tag, "_lat_valid"}, 32'(out_valid), 32'd1);
        got = 0; cyc = 0; finished = 1'b0; stalled = 1'b0; held = 8'h00;
        while (!finished && cyc < 2000) begin
            if (done) begin
                finished = 1'b1;
            end else begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_noerr"}, 32'(error), 32'd0);
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (stall) begin
                    start          = 1'($urandom_range(0, 1));
                    command_select = 2'($urandom());
                end
                if (stalled) check({tag, "_hold"}, 32'(out_byte), 32'(held));
                if (out_ready) begin
                    if (got < exp_q.size()) check($sformatf("%s_byte%0d", tag, got),
                                                  32'(out_byte), 32'(exp_q[got]));
                    else check({tag, "_overrun"}, 32'(got), 32'(exp_q.size()));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_byte;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_count"}, 32'(got), 32'(exp_q.size()));
        if (!stall) check({tag, "_cycles"}, 32'(cyc), 32'(exp_q.size()));
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    // Rejected request: one-cycle error, nothing emitted
    task automatic run_err(input string tag, input logic [1:0] cmd, input int len);
        command_select = cmd;
        payload_len    = LW'(len);
        payload_data   = rand_data();
        start          = 1'b1;
        out_ready      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err"}, 32'(error), 32'd1);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_err_clr"}, 32'(error), 32'd0);
        check({tag, "_valid2"}, 32'(out_valid), 32'd0);
        check({tag, "_busy2"}, 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [1:0] rcmd;
        int rlen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_byte", 32'(out_byte), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed command streams
        run_cmd("tx_abcd", 2'd1, 128'h44434241, 4, 1'b0);
        run_cmd("rx", 2'd2, rand_data(), 0, 1'b0);
        run_cmd("hex_a51f", 2'd3, 128'hA51F, 2, 1'b0);
        run_cmd("bp_len1", 2'd1, rand_data(), 1, 1'b1);
        run_cmd("raw_max", 2'd1, rand_data(), int'(MAXB), 1'b0);
        run_cmd("hex_max", 2'd3, rand_data(), int'(MAXB), 1'b1);

        // Randomized commands, random length and backpressure
        for (int n = 0; n < 8; n++) begin
            rcmd = 2'($urandom_range(1, 3));
            rlen = int'($urandom_range(1, MAXB));
            run_cmd($sformatf("rnd%0d", n), rcmd, rand_data(), rlen, 1'($urandom_range(0, 1)));
        end

        // Rejected requests
        run_err("err_cmd0", 2'd0, 3);
        run_err("err_len0", 2'd1, 0);
        run_err("err_lenmax1", 2'd1, int'(MAXB) + 1);
        run_err("err_hex_len0", 2'd3, 0);

        // Reset in the middle of a payload
        command_select = 2'd1;
        payload_len    = LW'(8);
        payload_data   = rand_data();
        start          = 1'b1;
        out_ready      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_byte", 32'(out_byte), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        run_cmd("rx_after_rst", 2'd2, rand_data(), 5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
